// File: rtl/dpi_timing_rx_pkg.sv
// dpi_timing_rx_pkg
// Shared definitions for the parallel-RGB (DPI) timing receiver: FSM state
// encoding, RGB565 field widths, line/column counter width and its
// saturation value, plus a saturating-increment helper.
package dpi_timing_rx_pkg;

    // RGB565 field widths
    localparam int unsigned RedW   = 5;
    localparam int unsigned GreenW = 6;
    localparam int unsigned BlueW  = 5;
    localparam int unsigned RgbW   = RedW + GreenW + BlueW;

    // Column / line / geometry counters
    localparam int unsigned    CntW   = 10;
    localparam logic [CntW-1:0] CntSat = {CntW{1'b1}};

    // Receiver lock FSM
    typedef enum logic [1:0] {
        StSearch,
        StMeasure,
        StVerify,
        StLocked
    } rx_state_e;

    // Increment that sticks at CntSat instead of wrapping
    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] val);
        return (val == CntSat) ? CntSat : val + {{(CntW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dpi_edge_det.sv
// dpi_edge_det
// Input synchroniser stage for the DPI timing signals. hsync/vsync are first
// normalised so that 1 always means "asserted", then registered twice
// (S1, S2). Edge pulses compare S1 against S2 and are valid in the cycle the
// new level sits in S1.
//
// Parameters:
//   HSYNC_ACT_LOW / VSYNC_ACT_LOW : 1 = sync asserted when the pin is 0
// Ports:
//   pxclk_i, rst_i          : pixel clock, async active-high reset
//   hsync_i, vsync_i, den_i : raw timing inputs
//   hsync_edge_o            : hsync became asserted
//   vsync_edge_o            : vsync became asserted
//   den_rise_o, den_fall_o  : data-enable edges
//   den_o                   : den level in S1
module dpi_edge_det #(
    parameter bit HSYNC_ACT_LOW = 1'b1,
    parameter bit VSYNC_ACT_LOW = 1'b1
) (
    input  logic pxclk_i,
    input  logic rst_i,
    input  logic hsync_i,
    input  logic vsync_i,
    input  logic den_i,
    output logic hsync_edge_o,
    output logic vsync_edge_o,
    output logic den_rise_o,
    output logic den_fall_o,
    output logic den_o
);

    // Bit order: {den, vsync, hsync}, syncs already polarity-normalised
    logic [2:0] s1_q, s1_d;
    logic [2:0] s2_q, s2_d;

    always_comb begin
        s1_d = {den_i, vsync_i ^ VSYNC_ACT_LOW, hsync_i ^ HSYNC_ACT_LOW};
        s2_d = s1_q;
    end

    always_ff @(posedge pxclk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign hsync_edge_o = s1_q[0] & ~s2_q[0];
    assign vsync_edge_o = s1_q[1] & ~s2_q[1];
    assign den_rise_o   = s1_q[2] & ~s2_q[2];
    assign den_fall_o   = ~s1_q[2] & s2_q[2];
    assign den_o        = s1_q[2];

endmodule

// File: rtl/dpi_timing_rx.sv
// dpi_timing_rx
// Parallel-RGB timing receiver. Measures active width/height of the incoming
// video, locks after LOCK_FRAMES consecutive frames match the measured
// geometry, and then forwards pixels tagged with column/line coordinates.
// Any geometry violation while locked pulses timing_err_o and drops lock.
//
// Optional feature: define DPI_TIMING_RX_FRAME_CNT_EN to enable the
// locked-frame counter on frame_cnt_o (otherwise tied to 0).
//
// Parameters:
//   HSYNC_ACT_LOW, VSYNC_ACT_LOW : sync polarity (1 = active low)
//   LOCK_FRAMES                  : matching frames needed to lock (1..15)
// Ports:
//   pxclk_i, rst_i                 : pixel clock, async active-high reset
//   hsync_i, vsync_i, den_i        : timing inputs
//   red_i, green_i, blue_i         : RGB565 pixel data, qualified by den_i
//   pixel_valid_o, rgb_o           : pixel of a locked frame (2-cycle latency)
//   col_o, lin_o                   : pixel coordinates in the active area
//   sof_o                          : pulse with pixel (0,0)
//   width_o, height_o              : captured active geometry
//   locked_o, timing_err_o         : lock status / loss-of-lock pulse
//   frame_cnt_o                    : locked-frame counter
module dpi_timing_rx
    import dpi_timing_rx_pkg::*;
#(
    parameter bit          HSYNC_ACT_LOW = 1'b1,
    parameter bit          VSYNC_ACT_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES   = 2
) (
    input  logic                pxclk_i,
    input  logic                rst_i,
    input  logic                hsync_i,
    input  logic                vsync_i,
    input  logic                den_i,
    input  logic [RedW-1:0]     red_i,
    input  logic [GreenW-1:0]   green_i,
    input  logic [BlueW-1:0]    blue_i,
    output logic                pixel_valid_o,
    output logic [RgbW-1:0]     rgb_o,
    output logic [8:0]          col_o,
    output logic [8:0]          lin_o,
    output logic                sof_o,
    output logic [CntW-1:0]     width_o,
    output logic [CntW-1:0]     height_o,
    output logic                locked_o,
    output logic                timing_err_o,
    output logic [15:0]         frame_cnt_o
);

    // ------------------------------------------------------------------
    // Stage S1/S2: timing edges and registered pixel data
    // ------------------------------------------------------------------
    logic hsync_edge_unused;
    logic vsync_edge, den_rise, den_fall, den_s1;

    dpi_edge_det #(
        .HSYNC_ACT_LOW (HSYNC_ACT_LOW),
        .VSYNC_ACT_LOW (VSYNC_ACT_LOW)
    ) u_edge_det (
        .pxclk_i      (pxclk_i),
        .rst_i        (rst_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .den_i        (den_i),
        .hsync_edge_o (hsync_edge_unused),
        .vsync_edge_o (vsync_edge),
        .den_rise_o   (den_rise),
        .den_fall_o   (den_fall),
        .den_o        (den_s1)
    );

    logic [RgbW-1:0] rgb_s1_q, rgb_s1_d;

    assign rgb_s1_d = {red_i, green_i, blue_i};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] col_q, col_d;
    logic [CntW-1:0] lin_q, lin_d;
    logic [CntW-1:0] width_q, width_d;
    logic [CntW-1:0] height_q, height_d;
    logic [3:0]      match_q, match_d;
    logic            wcap_q, wcap_d;       // first-line width already captured
    logic            meas_ok_q, meas_ok_d; // current MEASURE frame began at vsync
    logic            pix_valid_q, pix_valid_d;
    logic            sof_q, sof_d;
    logic            err_q, err_d;
    logic [RgbW-1:0] rgb_q, rgb_d;
    logic [8:0]      pix_col_q, pix_col_d;
    logic [8:0]      pix_lin_q, pix_lin_d;

    // ------------------------------------------------------------------
    // Counters and geometry measurement
    // ------------------------------------------------------------------
    logic [CntW-1:0] col_cur;     // column of the pixel currently in S1
    logic [CntW-1:0] width_meas;  // width of the line ending this cycle
    logic            width_sat;
    logic [CntW-1:0] lin_now;     // line count with a coincident line end applied
    logic            w_bad;
    logic            h_bad;
    logic [3:0]      match_next;

    always_comb begin
        col_cur    = den_rise ? '0 : sat_inc(col_q);
        col_d      = den_s1 ? col_cur : col_q;

        width_meas = col_q + {{(CntW-1){1'b0}}, 1'b1};
        width_sat  = (col_q == CntSat);

        // A line end coinciding with a vsync edge belongs to the ending frame
        lin_now    = den_fall ? sat_inc(lin_q) : lin_q;
        lin_d      = vsync_edge ? '0 : lin_now;

        w_bad      = width_sat || (width_meas != width_q);
        h_bad      = (lin_now == CntSat) || (lin_now == '0) || (lin_now != height_q);
        match_next = match_q + 4'd1;
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        match_d   = match_q;
        wcap_d    = wcap_q;
        meas_ok_d = meas_ok_q;
        err_d     = 1'b0;

        unique case (state_q)
            StSearch: begin
                if (vsync_edge) begin
                    state_d   = StMeasure;
                    meas_ok_d = 1'b1;
                    wcap_d    = 1'b0;
                end
            end

            StMeasure: begin
                if (den_fall && meas_ok_q && !wcap_q) begin
                    width_d = width_sat ? CntSat : width_meas;
                    wcap_d  = 1'b1;
                end
                if (vsync_edge) begin
                    if (meas_ok_q && wcap_d && (lin_now != CntSat) && (lin_now != '0)) begin
                        height_d = lin_now;
                        match_d  = '0;
                        state_d  = StVerify;
                    end
                    // Either way the next frame is measured from scratch
                    meas_ok_d = 1'b1;
                    wcap_d    = 1'b0;
                end
            end

            StVerify: begin
                if ((den_fall && w_bad) || (vsync_edge && h_bad)) begin
                    state_d   = StMeasure;
                    wcap_d    = 1'b0;
                    // Mid-frame mismatch: wait for the next vsync before measuring
                    meas_ok_d = vsync_edge;
                end else if (vsync_edge) begin
                    if (32'(match_next) == LOCK_FRAMES) begin
                        state_d = StLocked;
                    end else begin
                        match_d = match_next;
                    end
                end
            end

            StLocked: begin
                if ((den_fall && w_bad) || (vsync_edge && (h_bad || den_s1))) begin
                    err_d   = 1'b1;
                    state_d = StSearch;
                end
            end

            default: state_d = StSearch;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel output stage
    // ------------------------------------------------------------------
    always_comb begin
        pix_valid_d = (state_d == StLocked) && den_s1;
        sof_d       = pix_valid_d && den_rise && (lin_q == '0);
        rgb_d       = rgb_q;
        pix_col_d   = pix_col_q;
        pix_lin_d   = pix_lin_q;
        if (pix_valid_d) begin
            rgb_d     = rgb_s1_q;
            pix_col_d = col_cur[8:0];
            pix_lin_d = lin_q[8:0];
        end
    end

    always_ff @(posedge pxclk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_s1_q    <= '0;
            state_q     <= StSearch;
            col_q       <= '0;
            lin_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            match_q     <= '0;
            wcap_q      <= 1'b0;
            meas_ok_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            err_q       <= 1'b0;
            rgb_q       <= '0;
            pix_col_q   <= '0;
            pix_lin_q   <= '0;
        end else begin
            rgb_s1_q    <= rgb_s1_d;
            state_q     <= state_d;
            col_q       <= col_d;
            lin_q       <= lin_d;
            width_q     <= width_d;
            height_q    <= height_d;
            match_q     <= match_d;
            wcap_q      <= wcap_d;
            meas_ok_q   <= meas_ok_d;
            pix_valid_q <= pix_valid_d;
            sof_q       <= sof_d;
            err_q       <= err_d;
            rgb_q       <= rgb_d;
            pix_col_q   <= pix_col_d;
            pix_lin_q   <= pix_lin_d;
        end
    end

    // ------------------------------------------------------------------
    // Locked-frame counter
    // ------------------------------------------------------------------
`ifdef DPI_TIMING_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d != StLocked) begin
            frame_cnt_d = '0;
        end else if ((state_q == StLocked) && vsync_edge) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pxclk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    assign frame_cnt_o = '0;
`endif

    assign pixel_valid_o = pix_valid_q;
    assign rgb_o         = rgb_q;
    assign col_o         = pix_col_q;
    assign lin_o         = pix_lin_q;
    assign sof_o         = sof_q;
    assign width_o       = width_q;
    assign height_o      = height_q;
    assign locked_o      = (state_q == StLocked);
    assign timing_err_o  = err_q;

endmodule

// File: tb/tb_dpi_timing_rx.sv
`timescale 1ns/1ps
module tb_dpi_timing_rx;

    localparam int W = 20;
    localparam int H = 6;

    logic        pxclk_i = 1'b0;
    logic        rst_i   = 1'b1;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic        den_i   = 1'b0;
    logic [4:0]  red_i   = '0;
    logic [5:0]  green_i = '0;
    logic [4:0]  blue_i  = '0;
    logic        pixel_valid_o;
    logic [15:0] rgb_o;
    logic [8:0]  col_o;
    logic [8:0]  lin_o;
    logic        sof_o;
    logic [9:0]  width_o;
    logic [9:0]  height_o;
    logic        locked_o;
    logic        timing_err_o;
    logic [15:0] frame_cnt_o;

    dpi_timing_rx #(
        .HSYNC_ACT_LOW (1'b1),
        .VSYNC_ACT_LOW (1'b1),
        .LOCK_FRAMES   (2)
    ) dut (
        .pxclk_i       (pxclk_i),
        .rst_i         (rst_i),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .den_i         (den_i),
        .red_i         (red_i),
        .green_i       (green_i),
        .blue_i        (blue_i),
        .pixel_valid_o (pixel_valid_o),
        .rgb_o         (rgb_o),
        .col_o         (col_o),
        .lin_o         (lin_o),
        .sof_o         (sof_o),
        .width_o       (width_o),
        .height_o      (height_o),
        .locked_o      (locked_o),
        .timing_err_o  (timing_err_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 pxclk_i = ~pxclk_i;

    typedef struct packed {
        logic        sof;
        logic [8:0]  lin;
        logic [8:0]  col;
        logic [15:0] rgb;
    } pix_t;

    pix_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int          pv_cnt  = 0;
    int          sof_cnt = 0;
    int          err_cnt = 0;
    int unsigned err_cyc = 0;
    int unsigned last_end_cyc = 0;
    int unsigned short_end_cyc = 0;
    int          err0;

    always @(posedge pxclk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge pxclk_i) begin
        if (!rst_i) begin
            if (timing_err_o) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (pixel_valid_o) begin
                pv_cnt++;
                if (sof_o) sof_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 64'(pixel_valid_o), 64'(0));
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("pixel", 64'({sof_o, lin_o, col_o, rgb_o}), 64'(e));
                end
            end else if (sof_o) begin
                check("sof_without_valid", 64'(sof_o), 64'(0));
            end
        end
    end

    // One input cycle; syncs given as "asserted" (pins are active low)
    task automatic cyc1(input logic vs, input logic hs, input logic de, input logic [15:0] rgb);
        vsync_i = ~vs;
        hsync_i = ~hs;
        den_i   = de;
        {red_i, green_i, blue_i} = rgb;
        @(posedge pxclk_i);
        #1;
    endtask

    task automatic pixel(input int c, input int l, input bit exp_v);
        logic [15:0] rgb;
        pix_t        e;
        int          cs;
        rgb = 16'($urandom);
        cs  = (c > 1023) ? 1023 : c;
        if (exp_v) begin
            e.sof = (c == 0) && (l == 0);
            e.lin = 9'(l);
            e.col = 9'(cs);
            e.rgb = rgb;
            exp_q.push_back(e);
        end
        cyc1(1'b0, 1'b0, 1'b1, rgb);
    endtask

    task automatic vsync_pulse();
        repeat (2) cyc1(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (3) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic line(input int w, input int l, input bit exp_v);
        repeat (2) cyc1(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (2) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
        for (int c = 0; c < w; c++) pixel(c, l, exp_v);
        last_end_cyc = cyc;
        repeat (3) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic body(input bit exp_v, input int short_idx, input int short_w);
        bit v;
        v       = exp_v;
        pv_cnt  = 0;
        sof_cnt = 0;
        for (int l = 0; l < H; l++) begin
            line((l == short_idx) ? short_w : W, l, v);
            if (l == short_idx) begin
                short_end_cyc = last_end_cyc;
                v = 1'b0;
            end
        end
        repeat (3) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Three unlocked frames, then the vsync edge that must lock
    task automatic lock_seq();
        for (int i = 0; i < 3; i++) begin
            vsync_pulse();
            body(1'b0, -1, 0);
        end
        check("locked_before_4th_vsync", 64'(locked_o), 64'(0));
        vsync_pulse();
        check("locked_at_4th_vsync", 64'(locked_o), 64'(1));
        check("width", 64'(width_o), 64'(W));
        check("height", 64'(height_o), 64'(H));
    endtask

    task automatic locked_frame_checks();
        check("pixels_per_frame", 64'(pv_cnt), 64'(W * H));
        check("sof_per_frame", 64'(sof_cnt), 64'(1));
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        // Reset state
        repeat (3) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
        check("rst_pixel_valid", 64'(pixel_valid_o), 64'(0));
        check("rst_sof", 64'(sof_o), 64'(0));
        check("rst_locked", 64'(locked_o), 64'(0));
        check("rst_timing_err", 64'(timing_err_o), 64'(0));
        check("rst_geometry", 64'({width_o, height_o}), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt_o), 64'(0));
        rst_i = 1'b0;
        repeat (2) cyc1(1'b0, 1'b0, 1'b0, 16'h0);

        // Initial lock and locked frames
        lock_seq();
        check("no_err_during_lock", 64'(err_cnt), 64'(0));
        body(1'b1, -1, 0);
        locked_frame_checks();
        for (int i = 0; i < 4; i++) begin
            vsync_pulse();
            body(1'b1, -1, 0);
        end
        locked_frame_checks();
        vsync_pulse();
`ifdef DPI_TIMING_RX_FRAME_CNT_EN
        check("frame_cnt_after_5", 64'(frame_cnt_o), 64'(5));
`else
        check("frame_cnt_disabled", 64'(frame_cnt_o), 64'(0));
`endif
        check("geometry_stable", 64'({width_o, height_o}), 64'({10'(W), 10'(H)}));

        // Shortened line while locked
        err0 = err_cnt;
        body(1'b1, 2, W - 1);
        check("short_err_pulses", 64'(err_cnt - err0), 64'(1));
        check("short_err_latency", 64'(err_cyc - short_end_cyc), 64'(2));
        check("short_unlocked", 64'(locked_o), 64'(0));
        check("short_pixel_count", 64'(pv_cnt), 64'(2 * W + W - 1));
        check("short_frame_cnt_clear", 64'(frame_cnt_o), 64'(0));
        lock_seq();
        check("frame_cnt_at_relock", 64'(frame_cnt_o), 64'(0));
        body(1'b1, -1, 0);
        locked_frame_checks();

        // den held high across a vsync edge
        err0 = err_cnt;
        for (int c = 0; c < 3; c++) begin
            logic [15:0] rgb;
            pix_t        e;
            rgb   = 16'($urandom);
            e.sof = 1'b0;
            e.lin = 9'(H);
            e.col = 9'(c);
            e.rgb = rgb;
            exp_q.push_back(e);
            cyc1(1'b0, 1'b0, 1'b1, rgb);
        end
        cyc1(1'b1, 1'b0, 1'b1, 16'($urandom));
        cyc1(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (3) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
        check("den_vsync_err_pulses", 64'(err_cnt - err0), 64'(1));
        check("den_vsync_unlocked", 64'(locked_o), 64'(0));
        check("den_vsync_drained", 64'(exp_q.size()), 64'(0));
        lock_seq();
        body(1'b1, -1, 0);
        locked_frame_checks();

        // Asynchronous reset mid-line while locked
        vsync_pulse();
        for (int c = 0; c < 5; c++) pixel(c, 0, 1'b1);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        check("arst_pixel_valid", 64'(pixel_valid_o), 64'(0));
        check("arst_locked_err_sof", 64'({locked_o, timing_err_o, sof_o}), 64'(0));
        check("arst_geometry", 64'({width_o, height_o}), 64'(0));
        check("arst_data", 64'({rgb_o, col_o, lin_o}), 64'(0));
        check("arst_frame_cnt", 64'(frame_cnt_o), 64'(0));
        den_i = 1'b0;
        @(posedge pxclk_i);
        #1;
        repeat (2) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
        rst_i = 1'b0;
        err0  = err_cnt;
        lock_seq();
        check("arst_no_err", 64'(err_cnt - err0), 64'(0));
        body(1'b1, -1, 0);
        locked_frame_checks();

        // Saturating line width while locked
        vsync_pulse();
        err0 = err_cnt;
        line(1030, 0, 1'b1);
        repeat (3) cyc1(1'b0, 1'b0, 1'b0, 16'h0);
        check("sat_err_pulses", 64'(err_cnt - err0), 64'(1));
        check("sat_unlocked", 64'(locked_o), 64'(0));
        check("sat_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpi_timing_rx.md
DPI_TIMING_RX -- requirements
Module: dpi_timing_rx

Interface
REQ-001 Parameter HSYNC_ACT_LOW, default 1: hsync_i asserted level is 0 (1) or 1 (0).
REQ-002 Parameter VSYNC_ACT_LOW, default 1: vsync_i asserted level is 0 (1) or 1 (0).
REQ-003 Parameter LOCK_FRAMES, default 2: consecutive matching frames required before lock, range 1..15.
REQ-004 pxclk_i  in  1  pixel clock; sole clock, all logic on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 hsync_i, vsync_i, den_i  in  1 each  parallel-RGB timing from the panel source.
REQ-007 red_i  in  5; green_i  in  6; blue_i  in  5  pixel data, qualified by den_i.
REQ-008 pixel_valid_o  out  1  rgb_o/col_o/lin_o hold a valid pixel of a locked frame.
REQ-009 rgb_o  out  16  {red, green, blue} of the pixel.
REQ-010 col_o, lin_o  out  9 each  pixel column and line, 0-based within the active area.
REQ-011 sof_o  out  1  one-cycle pulse coincident with pixel (0,0) of a locked frame.
REQ-012 width_o, height_o  out  10 each  measured active pixels per line / active lines per frame.
REQ-013 locked_o  out  1; timing_err_o  out  1  one-cycle pulse on loss of lock.
REQ-014 frame_cnt_o  out  16  locked-frame counter (see Configuration).

Function
REQ-015 All inputs registered once (stage S1); edges detected S1 vs S2; data outputs registered, latency 2 pxclk_i cycles from den_i/data to pixel_valid_o/rgb_o.
REQ-016 Vsync edge = transition to asserted level; line end = den falling edge.
REQ-017 col counter: 0 on den rising edge, +1 per den-high cycle; saturates at 1023.
REQ-018 line counter: 0 at vsync edge, +1 at each line end; saturates at 1023.
REQ-019 FSM states SEARCH, MEASURE, VERIFY, LOCKED; reset state SEARCH.
REQ-020 SEARCH -> MEASURE at first vsync edge; partial frame before it discarded.
REQ-021 MEASURE: first line's width captured; at next vsync edge capture height, -> VERIFY with match count 0.
REQ-022 VERIFY: each line width and each frame height compared to captured values; full matching frame increments match count; count == LOCK_FRAMES -> LOCKED at that vsync edge.
REQ-023 Any mismatch in VERIFY -> MEASURE restarted at that frame (no error pulse).
REQ-024 LOCKED: pixel_valid_o = registered den; mismatch of any line width or frame height, den high at a vsync edge, or zero active lines in frame -> timing_err_o pulse, locked_o low, -> SEARCH same cycle.
REQ-025 Width mismatch is judged at line end; saturated counter (1023) always mismatches.
REQ-026 pixel_valid_o, sof_o never asserted outside LOCKED; col_o/lin_o/rgb_o hold last value when pixel_valid_o low.
REQ-027 width_o/height_o update only at capture in MEASURE; stable while LOCKED.
REQ-028 Simultaneous vsync edge and den falling edge: line end processed first, then frame end.

Reset
REQ-029 rst_i asynchronously clears: state SEARCH, all counters 0, all outputs 0 (locked_o 0, pixel_valid_o 0, sof_o 0, timing_err_o 0, width_o/height_o 0, frame_cnt_o 0).
REQ-030 Reset mid-frame: after release, re-lock requires full SEARCH/MEASURE/VERIFY sequence; no error pulse.

Configuration
REQ-031 Macro DPI_TIMING_RX_FRAME_CNT_EN defined: frame_cnt_o increments (wrap 65535->0) at every vsync edge while LOCKED, clears on loss of lock.
REQ-032 Macro undefined: frame_cnt_o tied to 0, no counter logic.

Structure
REQ-033 Shared package holds FSM state enum, RGB565 field widths, counter width (10) and saturation constant.
REQ-034 One sub-module dpi_edge_det: S1/S2 registering plus polarity-normalised edge pulses for hsync, vsync, den.

Verification
REQ-035 480x272 frames, LOCK_FRAMES=2 -> locked_o rises at 4th vsync edge after reset release; width_o=480, height_o=272.
REQ-036 Locked, one line shortened to 479 -> timing_err_o single pulse at that line end+2, locked_o 0, pixel_valid_o 0 until relock.
REQ-037 Locked frame -> sof_o with col_o=0, lin_o=0; last pixel col_o=479, lin_o=271; pixel_valid_o count per frame = 130560.
REQ-038 den_i held high across vsync edge while locked -> timing_err_o pulse, state SEARCH.
REQ-039 rst_i asserted mid-line while locked -> all outputs 0 asynchronously; relock after 4 vsync edges; no timing_err_o.
REQ-040 With DPI_TIMING_RX_FRAME_CNT_EN, 5 locked frames -> frame_cnt_o=5; without macro frame_cnt_o stays 0.
